// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if: request/byte inputs and transmit status outputs of uart_tx_scheduler
// master: requester side (drives req_i/data_i); slave: scheduler side (drives ack_o, grant_o, busy_o, done_o, TXD_o)
interface uart_tx_scheduler_if;
  logic [3:0]  req_i;
  logic [31:0] data_i;
  logic [3:0]  ack_o;
  logic [1:0]  grant_o;
  logic        busy_o;
  logic        done_o;
  logic        TXD_o;
  modport master (output req_i, data_i, input ack_o, grant_o, busy_o, done_o, TXD_o);
  modport slave (input req_i, data_i, output ack_o, grant_o, busy_o, done_o, TXD_o);
endinterface

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one 8N1 serial transmitter between four byte requesters
// Ports: clk_i system clock, rst_i asynchronous active-low reset, bus (uart_tx_scheduler_if.slave):
//   req_i[3:0] requests, data_i[31:0] bytes (requester k on [8k+7:8k]), ack_o one-hot latch pulse,
//   grant_o last granted index, busy_o frame in progress, done_o end-of-stop pulse, TXD_o serial line.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_scheduler #(
  parameter int DIV = 10
) (
  input logic clk_i,
  input logic rst_i,
  uart_tx_scheduler_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, `ifdef UART_TX_PARITY_EN PARITY, `endif STOP} state_t;
  state_t      st;
  logic [31:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  sh;
  logic [3:0]  ack;
  logic [1:0]  grant;
  logic [1:0]  pick;
  logic        busy, done, txd;
`ifdef UART_TX_PARITY_EN
  logic        par;
`endif
  wire wrap = cnt == 32'(DIV - 1);
  // grant_o doubles as the round-robin pointer; scanning k=4..1 lets the nearest successor win
  always_comb begin
    pick = grant;
    for (int k = 4; k >= 1; k--) pick = bus.req_i[2'(grant + 2'(k))] ? 2'(grant + 2'(k)) : pick;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      st <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      ack <= '0;
      grant <= 2'd3;
      busy <= 1'b0;
      done <= 1'b0;
      txd <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      ack <= '0;
      done <= 1'b0;
      if (st == IDLE) begin
        if (|bus.req_i) begin
          sh <= bus.data_i[{pick, 3'b000} +: 8];
`ifdef UART_TX_PARITY_EN
          par <= ^bus.data_i[{pick, 3'b000} +: 8];
`endif
          grant <= pick;
          ack <= 4'b0001 << pick;
          busy <= 1'b1;
          txd <= 1'b0;
          cnt <= '0;
          idx <= '0;
          st <= START;
        end
      end else begin
        cnt <= wrap ? '0 : cnt + 32'd1;
        if (wrap) begin
          case (st)
            START: begin
              txd <= sh[0];
              sh <= sh >> 1;
              st <= DATA;
            end
            DATA: begin
              idx <= idx + 3'd1;
              sh <= sh >> 1;
`ifdef UART_TX_PARITY_EN
              txd <= idx == 3'd7 ? par : sh[0];
              st <= idx == 3'd7 ? PARITY : DATA;
`else
              txd <= idx == 3'd7 ? 1'b1 : sh[0];
              st <= idx == 3'd7 ? STOP : DATA;
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
              txd <= 1'b1;
              st <= STOP;
            end
`endif
            STOP: begin
              busy <= 1'b0;
              done <= 1'b1;
              st <= IDLE;
            end
            default: st <= IDLE;
          endcase
        end
      end
    end
  end
  assign bus.ack_o = ack;
  assign bus.grant_o = grant;
  assign bus.busy_o = busy;
  assign bus.done_o = done;
  assign bus.TXD_o = txd;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: frame-timeline model of the shared UART transmitter checked every cycle, plus literal expectations
module tb_uart_tx_scheduler;
  localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif
  localparam int P = FL * DIV + 1;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int checks = 0;
  int failures = 0;
  uart_tx_scheduler_if bus();
  uart_tx_scheduler #(.DIV(DIV)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
  always #5 clk_i = ~clk_i;

  task automatic check(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      if (failures <= 40) $display("FAIL %s at %0t: got %0h expected %0h", n, $time, got, want);
    end
  endtask

  // Model: a frame is the bit list {stop, [parity], byte, start}, each bit DIV clocks, counted from the grant edge.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
`ifdef UART_TX_PARITY_EN
    logic [10:0] f = {1'b1, ^b, b, 1'b0};
`else
    logic [9:0] f = {1'b1, b, 1'b0};
`endif
    return f[i];
  endfunction

  int cyc = 0, t0 = 0, m_ptr = 3, pick;
  bit m_busy = 0;
  logic [7:0] m_byte = '0;
  logic [3:0] e_ack = '0;
  logic [1:0] e_grant = 2'd3;
  logic e_busy = 1'b0, e_done = 1'b0, e_txd = 1'b1;
  initial forever begin
    @(posedge clk_i or negedge rst_i);
    if (!rst_i) begin
      m_busy = 0; m_ptr = 3; e_ack = '0; e_grant = 2'd3; e_busy = 0; e_done = 0; e_txd = 1;
    end else begin
      e_ack = '0;
      e_done = 0;
      if (m_busy && cyc - t0 == FL * DIV) begin
        m_busy = 0;
        e_done = 1;
      end else if (!m_busy && bus.req_i != 0) begin
        pick = -1;
        for (int k = 1; k <= 4; k++) if (pick < 0 && bus.req_i[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
        m_ptr = pick;
        m_byte = bus.data_i[8 * pick +: 8];
        t0 = cyc;
        m_busy = 1;
        e_ack = 4'(1 << pick);
      end
      e_busy = m_busy;
      e_grant = 2'(m_ptr);
      e_txd = m_busy ? frame_bit(m_byte, (cyc - t0) / DIV) : 1'b1;
      cyc++;
    end
  end

  int ncyc = 0, gi;
  bit chk_en = 0;
  int a_q[$], g_q[$], d_q[$];
  logic txd_log [0:4095];
  initial forever begin
    @(negedge clk_i);
    if (chk_en) begin
      check("ack", 32'(bus.ack_o), 32'(e_ack));
      check("grant", 32'(bus.grant_o), 32'(e_grant));
      check("busy", 32'(bus.busy_o), 32'(e_busy));
      check("done", 32'(bus.done_o), 32'(e_done));
      check("txd", 32'(bus.TXD_o), 32'(e_txd));
    end
    if (bus.ack_o != 0) begin
      gi = -1;
      for (int k = 0; k < 4; k++) if (bus.ack_o[k]) gi = k;
      a_q.push_back(ncyc);
      g_q.push_back(gi);
    end
    if (bus.done_o) d_q.push_back(ncyc);
    if (ncyc < 4096) txd_log[ncyc] = bus.TXD_o;
    ncyc++;
  end

  function automatic int ag(input int i); return i < a_q.size() ? a_q[i] : -100000; endfunction
  function automatic int gg(input int i); return i < g_q.size() ? g_q[i] : -1; endfunction
  function automatic int dg(input int i); return i < d_q.size() ? d_q[i] : -100000; endfunction
  function automatic logic tx(input int i); return (i >= 0 && i < 4096) ? txd_log[i] : 1'bx; endfunction

  task automatic ticks(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic reset_dut();
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    ticks(2);
    #2 rst_i = 1'b1;
  endtask

  int ab, db, exp_bits[10], ap;
  logic [7:0] rb;
  initial begin
    exp_bits = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    bus.req_i = '0;
    bus.data_i = '0;
    ticks(3);
    chk_en = 1;
    check("rst_txd", 32'(bus.TXD_o), 1);
    check("rst_busy", 32'(bus.busy_o), 0);
    check("rst_grant", 32'(bus.grant_o), 3);
    check("rst_ack", 32'(bus.ack_o), 0);
    #2 rst_i = 1'b1;

    // single frame, byte 0xA5 from requester 0
    ab = a_q.size(); db = d_q.size();
    bus.data_i = 32'h0000_00A5;
    bus.req_i = 4'b0001;
    ticks(1);
    bus.req_i = '0;
    ticks(P + 4);
    check("t1_acks", a_q.size() - ab, 1);
    check("t1_grant", gg(ab), 0);
    check("t1_done_delay", dg(db) - ag(ab), FL * DIV);
    for (int i = 0; i < 9; i++) check("t1_bit", 32'(tx(ag(ab) + DIV * i + 1)), exp_bits[i]);
    check("t1_stop", 32'(tx(ag(ab) + DIV * (FL - 1) + 1)), 1);

    // all four requesting: 0,1,2,3,0, P clocks apart
    reset_dut();
    ab = a_q.size(); db = d_q.size();
    bus.data_i = 32'h4433_2211;
    bus.req_i = 4'b1111;
    ticks(1 + 4 * P);
    bus.req_i = '0;
    ticks(P + 4);
    check("t2_acks", a_q.size() - ab, 5);
    check("t2_dones", d_q.size() - db, 5);
    for (int i = 0; i < 5; i++) check("t2_order", gg(ab + i), i % 4);
    for (int i = 1; i < 5; i++) check("t2_spacing", ag(ab + i) - ag(ab + i - 1), P);

    // fairness: 2 held, 0 joins during 2's frame
    reset_dut();
    ab = a_q.size();
    bus.data_i = 32'h00C3_003C;
    bus.req_i = 4'b0100;
    ticks(10);
    bus.req_i = 4'b0101;
    ticks(3 * P + 1 - 10);
    bus.req_i = '0;
    ticks(P + 4);
    check("t3_acks", a_q.size() - ab, 4);
    check("t3_g0", gg(ab), 2);
    check("t3_g1", gg(ab + 1), 0);
    check("t3_g2", gg(ab + 2), 2);
    check("t3_g3", gg(ab + 3), 0);

    // data and request change mid-frame
    reset_dut();
    ab = a_q.size(); db = d_q.size();
    bus.data_i = 32'h0000_3C00;
    bus.req_i = 4'b0010;
    ticks(2 * DIV + 1);
    bus.data_i = 32'hFFFF_FFFF;
    bus.req_i = '0;
    ticks(P + 4);
    check("t4_acks", a_q.size() - ab, 1);
    check("t4_grant", gg(ab), 1);
    check("t4_done_delay", dg(db) - ag(ab), FL * DIV);
    for (int i = 0; i < 8; i++) rb[i] = tx(ag(ab) + DIV * (i + 1) + 1);
    check("t4_byte", 32'(rb), 32'h3C);

    // reset during bit 3 (a 0 bit), all requesters pending afterwards
    reset_dut();
    ab = a_q.size(); db = d_q.size();
    bus.data_i = 32'h0000_0042;
    bus.req_i = 4'b0001;
    ticks(1);
    bus.req_i = 4'b1111;
    ticks(17);
    check("t5_pre_txd", 32'(bus.TXD_o), 0);
    #2 rst_i = 1'b0;
    #1;
    check("t5_txd", 32'(bus.TXD_o), 1);
    check("t5_busy", 32'(bus.busy_o), 0);
    check("t5_grant", 32'(bus.grant_o), 3);
    ticks(3);
    #2 rst_i = 1'b1;
    ticks(1);
    bus.req_i = '0;
    ticks(P + 4);
    check("t5_acks", a_q.size() - ab, 2);
    check("t5_regrant", gg(ab + 1), 0);
    check("t5_dones", d_q.size() - db, 1);
    check("t5_done_delay", dg(db) - ag(ab + 1), FL * DIV);

`ifdef UART_TX_PARITY_EN
    // parity of 0x07 is 1; two frames P apart
    reset_dut();
    ab = a_q.size(); db = d_q.size();
    bus.data_i = 32'h0000_0007;
    bus.req_i = 4'b0001;
    ticks(1 + P);
    bus.req_i = '0;
    ticks(P + 4);
    ap = ag(ab);
    check("t6_parity", 32'(tx(ap + DIV * 9 + 1)), 1);
    check("t6_done_delay", dg(db) - ap, 44);
    check("t6_spacing", ag(ab + 1) - ap, 45);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
